// File: rtl/fp_widen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : fp_widen                                                       |
// | Brief   : IEEE-754 widening converter (EXP_IN/MAN_IN -> EXP_OUT/MAN_OUT) |
// |           behind valid/ready. FP_WIDEN_SUBNORM_EN enables subnormal      |
// |           normalisation; otherwise subnormals flush to signed zero.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fp_widen #(
  parameter int EXP_IN  = 8,
  parameter int MAN_IN  = 23,
  parameter int EXP_OUT = 11,
  parameter int MAN_OUT = 52
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [EXP_IN+MAN_IN:0]     in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_OUT+MAN_OUT:0]   out_data,
  output logic                       nan_exception
);

  localparam int c_BIAS_IN  = 2**(EXP_IN-1) - 1;
  localparam int c_BIAS_OUT = 2**(EXP_OUT-1) - 1;
  localparam int c_PAD      = MAN_OUT - MAN_IN;
  localparam logic [EXP_OUT-1:0] c_DELTA = EXP_OUT'(c_BIAS_OUT - c_BIAS_IN);
  localparam logic [MAN_OUT-1:0] c_QBIT  = {1'b1, {(MAN_OUT-1){1'b0}}};

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_CHECK = 2'd1;
  localparam logic [1:0] c_NORM  = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_next;
  logic               r_sign;
  logic [EXP_IN-1:0]  r_exp;
  logic [MAN_IN-1:0]  r_frac;
  logic [EXP_OUT-1:0] r_exp_out;
  logic [MAN_OUT-1:0] r_frac_out;
  logic               r_nan;

  logic               w_exp_zero;
  logic               w_exp_ones;
  logic               w_frac_zero;
  logic               w_subnorm;
  logic               w_snan;
  logic [MAN_OUT-1:0] w_frac_pad;

  assign w_exp_zero  = (r_exp == '0);
  assign w_exp_ones  = &r_exp;
  assign w_frac_zero = (r_frac == '0);
  assign w_subnorm   = w_exp_zero & ~w_frac_zero;
  assign w_snan      = w_exp_ones & ~w_frac_zero & ~r_frac[MAN_IN-1];
  assign w_frac_pad  = MAN_OUT'(r_frac) << c_PAD;

`ifdef FP_WIDEN_SUBNORM_EN
  // Working mantissa carries one guard bit above the fraction to detect the hidden one.
  logic [MAN_IN:0]    r_m;
  logic [EXP_OUT-1:0] r_e;
  logic [MAN_IN:0]    w_m_shl;
  logic [EXP_OUT-1:0] w_e_dec;
  logic               w_norm_done;
  logic [MAN_OUT-1:0] w_norm_frac;

  assign w_m_shl     = r_m << 1;
  assign w_e_dec     = r_e - 1'b1;
  assign w_norm_done = w_m_shl[MAN_IN];
  assign w_norm_frac = MAN_OUT'(w_m_shl[MAN_IN-1:0]) << c_PAD;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_m <= '0;
      r_e <= '0;
    end else if (r_state == c_CHECK) begin
      r_m <= {1'b0, r_frac};
      r_e <= EXP_OUT'(1) + c_DELTA;
    end else if (r_state == c_NORM) begin
      r_m <= w_m_shl;
      r_e <= w_e_dec;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= c_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:  if (in_valid) w_next = c_CHECK;
`ifdef FP_WIDEN_SUBNORM_EN
      c_CHECK: w_next = w_subnorm ? c_NORM : c_DONE;
      c_NORM:  if (w_norm_done) w_next = c_DONE;
`else
      c_CHECK: w_next = c_DONE;
      c_NORM:  w_next = c_IDLE;
`endif
      c_DONE:  if (out_ready) w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  always_comb begin
    in_ready      = (r_state == c_IDLE) && !reset;
    out_valid     = (r_state == c_DONE);
    nan_exception = out_valid & r_nan;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sign     <= 1'b0;
      r_exp      <= '0;
      r_frac     <= '0;
      r_exp_out  <= '0;
      r_frac_out <= '0;
      r_nan      <= 1'b0;
    end else begin
      if (r_state == c_IDLE && in_valid) begin
        {r_sign, r_exp, r_frac} <= in_data;
      end
      if (r_state == c_CHECK) begin
        r_nan <= w_snan;
        if (w_exp_ones) begin
          r_exp_out  <= '1;
          r_frac_out <= w_snan ? (w_frac_pad | c_QBIT) : w_frac_pad;
        end else if (w_exp_zero) begin
          // Zero; subnormals either flush here or are overwritten after NORM.
          r_exp_out  <= '0;
          r_frac_out <= '0;
        end else begin
          r_exp_out  <= EXP_OUT'(r_exp) + c_DELTA;
          r_frac_out <= w_frac_pad;
        end
      end
`ifdef FP_WIDEN_SUBNORM_EN
      if (r_state == c_NORM && w_norm_done) begin
        r_exp_out  <= w_e_dec;
        r_frac_out <= w_norm_frac;
      end
`endif
    end
  end

  assign out_data = {r_sign, r_exp_out, r_frac_out};

endmodule
`default_nettype wire

// File: tb/tb_fp_widen.sv
`default_nettype none
// Testbench for fp_widen (default binary32 -> binary64 parameters).
// Honours FP_WIDEN_SUBNORM_EN the same way the design does.
module tb_fp_widen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic        nan_exception;
  logic [63:0] out_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mode = 2;   // 0: random out_ready, 1: stall, 2: always ready

  typedef struct {
    logic [63:0] d;
    logic        n;
    int          due;
  } exp_t;
  exp_t q[$];
  bit seen = 0;
  bit prev_xfer = 0;

  fp_widen dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .nan_exception(nan_exception)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic int msb_pos(input logic [22:0] f);
    int p;
    p = -1;
    for (int i = 0; i < 23; i++) if (f[i]) p = i;
    return p;
  endfunction

  // Returns {nan_exception, out_data} from the numeric meaning of the input.
  function automatic logic [64:0] model(input logic [31:0] x);
    logic [7:0]  e;
    logic [22:0] f;
    logic [10:0] eo;
    logic [51:0] fo;
    logic [63:0] t;
    logic        n;
    int          p;
    e = x[30:23]; f = x[22:0];
    eo = '0; fo = '0; n = 1'b0; t = '0;
    p = msb_pos(f);
    if (e == 8'hFF) begin
      eo = 11'h7FF;
      fo = {f, 29'b0};
      if (f != 0 && f[22] == 1'b0) begin
        fo[51] = 1'b1;
        n = 1'b1;
      end
    end else if (e != 0) begin
      eo = 11'(int'(e) - 127 + 1023);
      fo = {f, 29'b0};
    end else if (f != 0) begin
`ifdef FP_WIDEN_SUBNORM_EN
      // value = f * 2^-149 = 1.xxx * 2^(p-149)
      eo = 11'(p - 149 + 1023);
      t  = 64'(f) << (52 - p);
      fo = t[51:0];
`endif
    end
    return {n, x[31], eo, fo};
  endfunction

  function automatic int latency(input logic [31:0] x);
`ifdef FP_WIDEN_SUBNORM_EN
    if (x[30:23] == 0 && x[22:0] != 0) return 2 + (23 - msb_pos(x[22:0]));
`endif
    return 2;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] x;
    int c;
    x = $urandom;
    c = $urandom_range(0, 5);
    case (c)
      0: x[30:0] = '0;
      1: begin
        x[30:23] = '0;
        x[22:0] = x[22:0] >> $urandom_range(0, 22);
        if (x[22:0] == 0) x[0] = 1'b1;
      end
      2: if (x[30:23] == 0 || x[30:23] == 8'hFF) x[30:23] = 8'h80;
      3: begin x[30:23] = 8'hFF; x[22:0] = '0; end
      4: begin x[30:23] = 8'hFF; x[22] = 1'b1; end
      default: begin
        x[30:23] = 8'hFF; x[22] = 1'b0;
        if (x[21:0] == 0) x[0] = 1'b1;
      end
    endcase
    return x;
  endfunction

  // Acceptance tracking and cycle count.
  initial forever begin
    logic [64:0] r;
    @(posedge clk);
    if (reset) begin
      q.delete();
    end else if (in_valid && in_ready) begin
      r = model(in_data);
      q.push_back('{d: r[63:0], n: r[64], due: cyc + latency(in_data)});
    end
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = (mode == 0) ? 1'($urandom_range(0, 1)) : (mode == 2);
  end

  // Compare process.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      prev_xfer = 0;
      seen = 0;
      continue;
    end
    if (prev_xfer) chk(in_ready == 1'b1, "in_ready_after_xfer", in_ready, 1);
    prev_xfer = 0;
    if (out_valid) begin
      chk(in_ready == 1'b0, "in_ready_while_busy", in_ready, 0);
      if (q.size() == 0) begin
        chk(0, "unexpected_out_valid", out_data, 0);
      end else begin
        if (!seen) begin
          chk(cyc == q[0].due, "latency", cyc, q[0].due);
          seen = 1;
        end
        chk(out_data == q[0].d, "out_data", out_data, q[0].d);
        chk(nan_exception == q[0].n, "nan_exception", nan_exception, q[0].n);
        if (out_ready) begin
          void'(q.pop_front());
          seen = 0;
          prev_xfer = 1;
        end
      end
    end else begin
      chk(nan_exception == 1'b0, "nan_when_idle", nan_exception, 0);
    end
  end

  task automatic send(input logic [31:0] d);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk(0, "send_timeout", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic wait_out(input logic level, input string name);
    int t;
    t = 0;
    while (out_valid !== level && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (out_valid !== level) chk(0, name, out_valid, level);
  endtask

  task automatic run_dir(input logic [31:0] x, input logic [63:0] d, input logic n, input string name);
    send(x);
    wait_out(1'b1, "dir_timeout");
    chk(out_data == d, name, out_data, d);
    chk(nan_exception == n, {name, "_nan"}, nan_exception, n);
    wait_out(1'b0, "dir_release_timeout");
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] d0;
    repeat (3) @(negedge clk);
    chk(in_ready == 1'b0, "rst_in_ready", in_ready, 0);
    chk(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
    chk(out_data == 64'h0, "rst_out_data", out_data, 0);
    chk(nan_exception == 1'b0, "rst_nan", nan_exception, 0);
    reset = 1'b0;
    #1;
    chk(in_ready == 1'b1, "in_ready_after_rst", in_ready, 1);

    mode = 2;
    run_dir(32'h3F800000, 64'h3FF0000000000000, 1'b0, "one");
    run_dir(32'h7FA00001, 64'h7FFC000020000000, 1'b1, "snan");
    run_dir(32'h7FC00000, 64'h7FF8000000000000, 1'b0, "qnan");
    run_dir(32'hFF800000, 64'hFFF0000000000000, 1'b0, "neg_inf");
    run_dir(32'h80000000, 64'h8000000000000000, 1'b0, "neg_zero");
`ifdef FP_WIDEN_SUBNORM_EN
    run_dir(32'h00000001, 64'h36A0000000000000, 1'b0, "subnorm_min");
    run_dir(32'h80400000, 64'hB800000000000000, 1'b0, "subnorm_max_bit");
`else
    run_dir(32'h00000001, 64'h0000000000000000, 1'b0, "subnorm_flush");
    run_dir(32'h80400000, 64'h8000000000000000, 1'b0, "subnorm_flush_neg");
`endif

    // Backpressure hold.
    mode = 1;
    @(negedge clk);
    send(32'h40490FDB);
    wait_out(1'b1, "bp_timeout");
    d0 = out_data;
    chk(d0 == 64'h400921FB60000000, "bp_value", d0, 64'h400921FB60000000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk(out_valid == 1'b1, "bp_valid_hold", out_valid, 1);
      chk(out_data == d0, "bp_data_hold", out_data, d0);
      chk(in_ready == 1'b0, "bp_in_ready", in_ready, 0);
    end
    mode = 2;
    wait_out(1'b0, "bp_release_timeout");
    chk(in_ready == 1'b1, "bp_in_ready_after", in_ready, 1);

    // Reset while the subnormal is in flight.
    mode = 1;
    send(32'h00000001);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk(out_valid == 1'b0, "midrst_out_valid", out_valid, 0);
    chk(out_data == 64'h0, "midrst_out_data", out_data, 0);
    chk(in_ready == 1'b1, "midrst_in_ready", in_ready, 1);
    mode = 2;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) chk(0, "midrst_spurious_valid", out_valid, 0);
    end

    // Randomized traffic with random backpressure.
    mode = 0;
    for (int i = 0; i < 300; i++) begin
      send(rand_fp());
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    begin
      int t;
      t = 0;
      while (q.size() != 0 && t < 500) begin
        @(negedge clk);
        t++;
      end
      chk(q.size() == 0, "drain", q.size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
